// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-stage defaults and state encoding.
package cpu_fetch_pkg;
  localparam int          DEF_ADDR_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  localparam int          INST_W       = 32;
  typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: drives a sync-read instruction memory and presents a valid/ready stream with redirects and range faults.
module inst_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                MEM_DEPTH = 21,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_word,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault,
  output logic [CNT_W-1:0]  fetch_count
);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic              req_v_q, req_v_d, fault_q, fault_d, stall;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      req_v_q  <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      req_v_q  <= req_v_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_v_d  = req_v_q;
    fault_d  = fault_q;
    cnt_d    = (inst_valid && inst_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    if (redirect_valid) begin
      if (redirect_pc < DEPTH) begin
        state_d  = RUN;
        fault_d  = 1'b0;
        req_pc_d = redirect_pc;
        req_v_d  = 1'b1;
        pc_d     = redirect_pc + 1'b1;
      end else begin
        state_d = HALT;
        fault_d = 1'b1;
        req_v_d = 1'b0;
      end
    end else if (state_q == RUN && !stall) begin
      if (pc_q < DEPTH) begin
        req_pc_d = pc_q;
        req_v_d  = 1'b1;
        pc_d     = pc_q + 1'b1;
      end else begin
        state_d = HALT;
        fault_d = 1'b1;
        req_v_d = 1'b0;
      end
    end
  end
  // A stall re-reads the held address so the memory keeps driving the same word.
  always_comb begin
    inst_valid  = req_v_q && state_q == RUN && !redirect_valid;
    stall       = inst_valid && !inst_ready;
    imem_addr   = !rst_n ? RESET_PC : redirect_valid ? redirect_pc : stall ? req_pc_q : pc_q;
    inst_word   = imem_rdata;
    inst_pc     = req_pc_q;
    fault       = fault_q;
    fetch_count = cnt_q;
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed plus random stimulus against a presented-instruction stream model.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_word, inst_pc;
  logic        redirect_valid = 1'b0, inst_ready = 1'b1, inst_valid, fault;
  logic [15:0] fetch_count;
  int          n_chk = 0, n_fail = 0;
  int          cur, cnt;
  bit          live, halted;
  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_word(inst_word), .inst_pc(inst_pc),
    .fault(fault), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a < 32'd21 ? 32'h1000_0000 + a : 32'hdead_beef;
  endfunction
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    cur = -1;
    live = 0;
    halted = 0;
    cnt = 0;
  endtask
  task automatic step(input bit rdy, input bit rv, input int rpc);
    bit v;
    inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc = 32'(rpc);
    #1;
    v = live && !halted && !rv;
    chk("valid", 64'(inst_valid), 64'(v));
    chk("fault", 64'(fault), 64'(halted));
    chk("count", 64'(fetch_count), 64'(cnt));
    if (v) begin
      chk("pc", 64'(inst_pc), 64'(cur));
      chk("word", 64'(inst_word), 64'(32'h1000_0000 + cur));
    end
    @(posedge clk);
    if (v && rdy && cnt < 65535) cnt++;
    if (rv) begin
      if (rpc < 21) begin
        cur = rpc;
        live = 1;
        halted = 0;
      end else begin
        live = 0;
        halted = 1;
      end
    end else if (!halted) begin
      if (!live) begin
        cur++;
        live = 1;
      end else if (rdy) begin
        if (cur + 1 < 21) cur++;
        else begin
          live = 0;
          halted = 1;
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    model_reset();
    redirect_pc = '0;
    #12;
    chk("rst_valid", 64'(inst_valid), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    chk("rst_addr", 64'(imem_addr), 64'(0));
    chk("rst_count", 64'(fetch_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 12);
    repeat (12) step(1, 0, 0);
    chk("halt_fault", 64'(fault), 64'(1));
    step(1, 1, 3);
    repeat (3) step(1, 0, 0);
    step(1, 1, 25);
    repeat (2) step(1, 0, 0);
    step(1, 1, 9);
    repeat (2) step(0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(inst_valid), 64'(0));
    chk("mid_rst_count", 64'(fetch_count), 64'(0));
    chk("mid_rst_fault", 64'(fault), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) step(1, 0, 0);
    chk("count8", 64'(fetch_count), 64'(8));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) step($urandom_range(0, 3) != 0, 1, int'($urandom_range(0, 27)));
      else step($urandom_range(0, 3) != 0, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
